// File: rtl/uart_mmio_bridge.sv
// MMIO bridge between the CPU MEM stage and the UART: TX/RX byte FIFOs,
// sticky TX overflow, cycle/instret counters, and one-cycle registered load data.
module uart_mmio_bridge #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [7:0] REG_STATUS  = 8'h00;
    localparam logic [7:0] REG_RX_DATA = 8'h04;
    localparam logic [7:0] REG_TX_DATA = 8'h08;
    localparam logic [7:0] REG_CYCLE   = 8'h10;
    localparam logic [7:0] REG_INSTRET = 8'h14;
    localparam logic [7:0] REG_CNT_CLR = 8'h18;
    localparam logic [7:0] REG_OCC     = 8'h1C;

    logic [7:0] off;
    logic       rd_act;
    logic       wr_act;

    // A store wins over a load issued in the same cycle.
    assign off    = {addr[7:2], 2'b00};
    assign wr_act = wr_en & addr[31];
    assign rd_act = rd_en & ~wr_en & addr[31];

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr;
    logic [AW-1:0] tx_rd_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_req;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_overflow;

    assign tx_full  = (tx_count == FULL);
    assign tx_empty = (tx_count == '0);
    assign tx_pop   = ~tx_empty & tx_ready;
    assign tx_req   = wr_act & (off == REG_TX_DATA);
    // A full FIFO still takes the byte when the head leaves on the same edge.
    assign tx_push  = tx_req & (~tx_full | tx_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage arrays are left unreset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            tx_overflow <= 1'b0;
        else if (tx_req && !tx_push)
            tx_overflow <= 1'b1;
        else if (wr_act && off == REG_STATUS)
            tx_overflow <= 1'b0;
    end

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr;
    logic [AW-1:0] rx_rd_ptr;
    logic [CW-1:0] rx_count;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_pop;

    assign rx_empty = (rx_count == '0);
    assign rx_ready = (rx_count != FULL);
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_act & (off == REG_RX_DATA) & ~rx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    // ---------------- Counters ----------------
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
    logic             cnt_clr;

    assign cnt_clr = wr_act & (off == REG_CNT_CLR);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (inst_retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end

    // ---------------- Read path ----------------
    logic [31:0] rd_val;

    // NOTE: combinational blocks assign a default first so no path leaves a latch.
    always_comb begin
        rd_val = '0;
        case (off)
            REG_STATUS:  rd_val = {29'b0, tx_overflow, ~rx_empty, ~tx_full};
            REG_RX_DATA: rd_val = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rd_ptr]};
            REG_CYCLE:   rd_val = 32'(cycle_cnt);
            REG_INSTRET: rd_val = 32'(instret_cnt);
            REG_OCC:     rd_val = {16'b0, 8'(tx_count), 8'(rx_count)};
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (rd_act)
            rdata <= rd_val;
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, addr[30:8], addr[1:0], wdata[31:8]};

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_uart_mmio_bridge;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic        inst_retire;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    logic [31:0] rdata_s;
    logic [7:0]  unused_tx_data_s;
    logic        unused_tx_valid_s;
    logic        unused_rx_ready_s;

    int vectors = 0;
    int errors  = 0;

    uart_mmio_bridge #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .rd_en(rd_en), .wr_en(wr_en), .inst_retire(inst_retire),
        .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    // Narrow-counter copy so counter wrap is reachable in a short run.
    uart_mmio_bridge #(.DEPTH(DEPTH), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .rd_en(rd_en), .wr_en(wr_en), .inst_retire(inst_retire),
        .rdata(rdata_s), .tx_data(unused_tx_data_s), .tx_valid(unused_tx_valid_s),
        .tx_ready(1'b0), .rx_data(8'h00), .rx_valid(1'b0), .rx_ready(unused_rx_ready_s)
    );

    always #5 clk = ~clk;

    // ---------------- Behavioural model ----------------
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          m_ovf;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_read(logic [7:0] off);
        case (off)
            8'h00:   return {29'b0, m_ovf, rxq.size() != 0, txq.size() != DEPTH};
            8'h04:   return (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0;
            8'h10:   return m_cyc;
            8'h14:   return m_ins;
            8'h1C:   return {16'b0, 8'(txq.size()), 8'(rxq.size())};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] off;
        bit rd, t_pop, r_push, r_pop;
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_ovf = 0; m_cyc = 0; m_ins = 0; m_rdata = 0;
            return;
        end
        off    = {addr[7:2], 2'b00};
        rd     = rd_en && !wr_en;
        t_pop  = (txq.size() > 0) && tx_ready;
        r_push = rx_valid && (rxq.size() < DEPTH);
        r_pop  = rd && off == 8'h04 && rxq.size() > 0;
        if (rd) m_rdata = model_read(off);
        if (t_pop) void'(txq.pop_front());
        if (wr_en && off == 8'h08) begin
            if (txq.size() < DEPTH) txq.push_back(wdata[7:0]);
            else m_ovf = 1;
        end
        if (wr_en && off == 8'h00) m_ovf = 0;
        if (r_pop) void'(rxq.pop_front());
        if (r_push) rxq.push_back(rx_data);
        if (wr_en && off == 8'h18) begin
            m_cyc = 0;
            m_ins = 0;
        end else begin
            m_cyc++;
            if (inst_retire) m_ins++;
        end
    endtask

    // ---------------- Drivers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_store(input logic [7:0] off, input logic [31:0] data);
        addr  = {24'h800000, off};
        wdata = data;
        wr_en = 1'b1;
        rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] off);
        addr  = {24'h800000, off};
        rd_en = 1'b1;
        wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; inst_retire = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        addr = 32'h8000_0000; wdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        do_reset();
        vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        vectors++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        do_load(8'h00);
        vectors++; if (rdata !== 32'h1) begin errors++; $display("FAIL reset_status: got %h want %h", rdata, 32'h1); end
        do_load(8'h1C);
        vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_occ: got %h want %h", rdata, 32'h0); end
    endtask

    task automatic test_tx_burst();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_store(8'h08, 32'h41 + i);
            if (i == 0) begin
                vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
                    errors++; $display("FAIL tx_first_valid: got %b/%h want 1/41", tx_valid, tx_data);
                end
            end
        end
        do_store(8'h08, 32'h49);
        do_load(8'h00);
        vectors++; if (rdata !== 32'h4) begin errors++; $display("FAIL tx_overflow_status: got %h want %h", rdata, 32'h4); end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                errors++; $display("FAIL tx_drain[%0d]: got %b/%h want 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            tick();
        end
        tx_ready = 1'b0;
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_extra_byte: got valid=%b data=%h want empty", tx_valid, tx_data); end
        do_store(8'h00, 32'hDEAD_BEEF);
        do_load(8'h00);
        vectors++; if (rdata !== 32'h1) begin errors++; $display("FAIL tx_overflow_clear: got %h want %h", rdata, 32'h1); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b;
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_store(8'h08, 32'h60 + i);
        tx_ready = 1'b1;
        do_store(8'h08, 32'h55);
        tx_ready = 1'b0;
        do_load(8'h1C);
        vectors++; if (rdata !== 32'h0000_0800) begin errors++; $display("FAIL full_pp_count: got %h want %h", rdata, 32'h0000_0800); end
        do_load(8'h00);
        vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL full_pp_status: got %h want %h", rdata, 32'h0); end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = (i == DEPTH - 1) ? 8'h55 : 8'(8'h61 + i);
            vectors++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                errors++; $display("FAIL full_pp_drain[%0d]: got %b/%h want 1/%h", i, tx_valid, tx_data, exp_b);
            end
            tick();
        end
        tx_ready = 1'b0;
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty: got %b want 0", tx_valid); end
    endtask

    task automatic test_rx();
        logic [31:0] exp_seq [7];
        logic [7:0]  offs [7];
        do_reset();
        rx_valid = 1'b1;
        rx_data = 8'h10; tick();
        rx_data = 8'h20; tick();
        rx_data = 8'h30; tick();
        rx_valid = 1'b0;
        offs    = '{8'h04, 8'h04, 8'h00, 8'h04, 8'h00, 8'h04, 8'h1C};
        exp_seq = '{32'h10, 32'h20, 32'h3, 32'h30, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            do_load(offs[i]);
            vectors++; if (rdata !== exp_seq[i]) begin
                errors++; $display("FAIL rx_seq[%0d] off %h: got %h want %h", i, offs[i], rdata, exp_seq[i]);
            end
        end
        rx_valid = 1'b1; rx_data = 8'h77; tick();
        rx_data = 8'h88;
        do_load(8'h04);
        rx_valid = 1'b0;
        vectors++; if (rdata !== 32'h77) begin errors++; $display("FAIL rx_one_entry_old: got %h want %h", rdata, 32'h77); end
        do_load(8'h04);
        vectors++; if (rdata !== 32'h88) begin errors++; $display("FAIL rx_one_entry_new: got %h want %h", rdata, 32'h88); end
    endtask

    task automatic test_rx_full();
        do_reset();
        rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'(8'hA0 + i);
            tick();
        end
        rx_data = 8'hA8;
        vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
        tick();
        tick();
        vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_hold: got %b want 0", rx_ready); end
        do_load(8'h04);
        vectors++; if (rdata !== 32'hA0 || rx_ready !== 1'b1) begin
            errors++; $display("FAIL rx_full_pop: got %h/%b want a0/1", rdata, rx_ready);
        end
        tick();
        rx_valid = 1'b0;
        vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_accept: got %b want 0", rx_ready); end
        for (int i = 1; i <= DEPTH; i++) begin
            do_load(8'h04);
            vectors++; if (rdata !== 32'(8'hA0 + i)) begin
                errors++; $display("FAIL rx_full_drain[%0d]: got %h want %h", i, rdata, 32'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_counters();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            inst_retire = (i == 2 || i == 5 || i == 9 || i == 13 || i == 17);
            tick();
        end
        inst_retire = 1'b0;
        do_load(8'h10);
        vectors++; if (rdata !== 32'd20 || rdata_s !== 32'd4) begin
            errors++; $display("FAIL cnt_cycle: got %0d/%0d want 20/4", rdata, rdata_s);
        end
        do_load(8'h14);
        vectors++; if (rdata !== 32'd5 || rdata_s !== 32'd5) begin
            errors++; $display("FAIL cnt_instret: got %0d/%0d want 5/5", rdata, rdata_s);
        end
        do_store(8'h18, 32'h0);
        do_load(8'h10);
        vectors++; if (rdata !== 32'd0) begin errors++; $display("FAIL cnt_clear_edge: got %0d want 0", rdata); end
        do_load(8'h10);
        vectors++; if (rdata !== 32'd1) begin errors++; $display("FAIL cnt_after_clear: got %0d want 1", rdata); end
        for (int i = 0; i < 40 && m_cyc != 32'd17; i++) tick();
        do_load(8'h10);
        vectors++; if (rdata !== 32'd17 || rdata_s !== 32'd1) begin
            errors++; $display("FAIL cnt_cycle_wrap: got %0d/%0d want 17/1", rdata, rdata_s);
        end
        do_store(8'h18, 32'h0);
        inst_retire = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        inst_retire = 1'b0;
        do_load(8'h14);
        vectors++; if (rdata !== 32'd18 || rdata_s !== 32'd2) begin
            errors++; $display("FAIL cnt_instret_wrap: got %0d/%0d want 18/2", rdata, rdata_s);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_store(8'h08, 32'h11);
        do_store(8'h08, 32'h22);
        do_load(8'h1C);
        vectors++; if (rdata !== 32'h0200) begin errors++; $display("FAIL b2b_occ: got %h want %h", rdata, 32'h0200); end
        addr = 32'h8000_0008; wdata = 32'h33; rd_en = 1'b1; wr_en = 1'b1;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        vectors++; if (rdata !== 32'h0200) begin errors++; $display("FAIL b2b_rdwr_hold: got %h want %h", rdata, 32'h0200); end
        do_load(8'h1C);
        vectors++; if (rdata !== 32'h0300) begin errors++; $display("FAIL b2b_rdwr_push: got %h want %h", rdata, 32'h0300); end
    endtask

    task automatic test_random();
        logic [7:0] offs [12];
        logic [7:0] exp_tx;
        offs = '{8'h00, 8'h04, 8'h08, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h04, 8'h08};
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            addr        = {1'b1, 23'($urandom), offs[$urandom_range(0, 11)] | 8'($urandom_range(0, 3))};
            wdata       = $urandom;
            rd_en       = ($urandom_range(0, 9) < 4);
            wr_en       = ($urandom_range(0, 9) < 4);
            inst_retire = $urandom_range(0, 1);
            tx_ready    = ($urandom_range(0, 9) < 3);
            rx_valid    = $urandom_range(0, 1);
            rx_data     = 8'($urandom);
            tick();
            exp_tx = (txq.size() != 0) ? txq[0] : 8'h00;
            vectors++; if (rdata !== m_rdata) begin
                errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rdata, m_rdata);
            end
            vectors++; if (tx_valid !== (txq.size() != 0) || tx_data !== exp_tx) begin
                errors++; $display("FAIL rand_tx[%0d]: got %b/%h want %b/%h", n, tx_valid, tx_data, txq.size() != 0, exp_tx);
            end
            vectors++; if (rx_ready !== (rxq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_rx_ready[%0d]: got %b want %b", n, rx_ready, rxq.size() < DEPTH);
            end
        end
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; inst_retire = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_burst();
        test_full_push_pop();
        test_rx();
        test_rx_full();
        test_counters();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
